dma_sram: RTL and testbench

Parametrised simulation/synthesis memory model for the GameBoy address space with a built-in OAM-style block-copy engine. It replaces the flat tri-state model with separate read and write data paths and a registered read. A CPU write to the DMA trigger register copies `DMA_LEN` bytes from page `{value, 8'h00}` to `DMA_DST`. The block sits between the CPU bus interface and the rest of the memory map.

---
 rtl/dma_sram.sv | 120 ++++++++++++
 tb/tb_dma_sram.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sram.sv
// GameBoy address-space memory with separate read/write paths, a registered read port
// and an OAM-style block-copy engine started by a CPU write to the trigger register.
module dma_sram #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 8,
  parameter logic [15:0] DMA_REG   = 16'hFF46,
  parameter logic [15:0] DMA_DST   = 16'hFE00,
  parameter int          DMA_LEN   = 160,
  parameter logic [15:0] HRAM_LO   = 16'hFF80,
  parameter string       INIT_FILE = "memory.hex"
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic              we,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              dma_busy,
  output logic              dma_done
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  localparam logic [ADDR_W-1:0] REG_A    = ADDR_W'(DMA_REG);
  localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DMA_DST);
  localparam logic [ADDR_W-1:0] HRAM_A   = ADDR_W'(HRAM_LO);
  localparam logic [7:0]        LAST_CNT = 8'(DMA_LEN - 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        src_page_q, src_page_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic              locked, trigger, cpu_we, dma_we;
  logic [ADDR_W-1:0] src_addr, dst_addr;

  assign dma_busy = (state_q == S_READ) || (state_q == S_WRITE);
  assign dma_done = (state_q == S_DONE);
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;

  // The trigger register sits below HRAM but must stay writable during a copy.
  assign locked   = dma_busy && (addr < HRAM_A);
  assign trigger  = we && (addr == REG_A);
  assign cpu_we   = we && (!locked || trigger);
  assign dma_we   = (state_q == S_WRITE);
  assign src_addr = ADDR_W'({src_page_q, 8'h00}) + ADDR_W'(cnt_q);
  assign dst_addr = DST_A + ADDR_W'(cnt_q);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (re && !we) begin
      rvalid_d = 1'b1;
      rdata_d  = locked ? '1 : mem[addr];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    src_page_d = src_page_q;
    hold_d     = hold_q;
    case (state_q)
      S_READ: begin
        hold_d  = mem[src_addr];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    // A trigger restarts from the new page whatever the engine was doing.
    if (trigger) begin
      src_page_d = wdata[7:0];
      cnt_d      = 8'd0;
      state_d    = S_READ;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      src_page_q <= 8'd0;
      hold_q     <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      src_page_q <= src_page_d;
      hold_q     <= hold_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps its contents across rst_b.
  always_ff @(posedge clk) begin
    if (cpu_we) mem[addr]     <= wdata;
    if (dma_we) mem[dst_addr] <= hold_q;
  end

endmodule

// File: tb/tb_dma_sram.sv
// Self-checking bench for dma_sram: CPU access, full copy, lockout, restart,
// reset abort and high-page source, with read results checked through a scoreboard queue.
module tb_dma_sram;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  rdata;
  logic        rvalid, dma_busy, dma_done;

  dma_sram #(.INIT_FILE("")) dut (
    .clk(clk), .rst_b(rst_b), .addr(addr), .wdata(wdata), .re(re), .we(we),
    .rdata(rdata), .rvalid(rvalid), .dma_busy(dma_busy), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int busy_run = 0;
  int done_cnt = 0;
  bit overlap = 1'b0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dma_busy) busy_run++;
    if (dma_done) done_cnt++;
    if (dma_busy && dma_done) overlap = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; wdata = d; we = 1'b1; re = 1'b0;
    @(posedge clk); #1; we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    @(negedge clk); addr = a; re = 1'b1; we = 1'b0; sb.push_back(e);
    @(posedge clk); #1; re = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk); #1;
      if (dma_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({rdata, rvalid, dma_busy, dma_done} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_state: got rdata=%h rvalid=%b busy=%b done=%b required all 0",
               rdata, rvalid, dma_busy, dma_done);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] e;
    wr(16'hC000, 8'hA5);
    rd(16'hC000, 8'hA5);
    e = sb.pop_front(); n_tests++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_fail++; $display("FAIL basic_read: got %h/%b required %h/1", rdata, rvalid, e);
    end
    @(negedge clk); addr = 16'hC001; wdata = 8'h5A; re = 1'b1; we = 1'b1;
    @(posedge clk); #1; re = 1'b0; we = 1'b0;
    n_tests++;
    if (rvalid !== 1'b0 || rdata !== 8'hA5) begin
      n_fail++; $display("FAIL re_we_both: got %h/%b required A5/0", rdata, rvalid);
    end
    rd(16'hC001, 8'h5A);
    e = sb.pop_front(); n_tests++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_fail++; $display("FAIL write_wins: got %h/%b required %h/1", rdata, rvalid, e);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rvalid !== 1'b0 || rdata !== 8'h5A) begin
      n_fail++; $display("FAIL rdata_hold: got %h/%b required 5A/0", rdata, rvalid);
    end
  endtask

  task automatic test_full_copy();
    int b0, d0, t0, lat;
    bit ok;
    logic [7:0] e;
    for (int i = 0; i < 160; i++) wr(16'hC000 + 16'(i), 8'(i));
    wr(16'hFEA0, 8'h77);
    wr(16'hC100, 8'hAA);
    wr(16'hFF80, 8'h00);
    b0 = busy_run; d0 = done_cnt;
    wr(16'hFF46, 8'hC0);
    t0 = cyc;
    n_tests++;
    if (dma_busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_rise: got %b required 1", dma_busy);
    end
    wr(16'hC100, 8'h55);
    rd(16'hC100, 8'hFF);
    e = sb.pop_front(); n_tests++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_fail++; $display("FAIL lockout_read: got %h/%b required %h/1", rdata, rvalid, e);
    end
    wr(16'hFF80, 8'h3C);
    rd(16'hFF80, 8'h3C);
    e = sb.pop_front(); n_tests++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_fail++; $display("FAIL hram_access: got %h/%b required %h/1", rdata, rvalid, e);
    end
    wait_done(400, ok);
    lat = cyc - t0;
    n_tests++;
    if (!ok || lat != 320) begin
      n_fail++; $display("FAIL done_latency: got ok=%b cycles=%0d required 320", ok, lat);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy_run - b0 != 320) begin
      n_fail++; $display("FAIL busy_cycles: got %0d required 320", busy_run - b0);
    end
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL done_pulses: got %0d required 1", done_cnt - d0);
    end
    n_tests++;
    if (overlap !== 1'b0) begin
      n_fail++; $display("FAIL done_busy_overlap: got 1 required 0");
    end
    for (int i = 0; i < 160; i++) begin
      rd(16'hFE00 + 16'(i), 8'(i));
      e = sb.pop_front(); n_tests++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_fail++; $display("FAIL copy_fe%02h: got %h/%b required %h/1", i, rdata, rvalid, e);
      end
    end
    rd(16'hFEA0, 8'h77);
    rd(16'hFF46, 8'hC0);
    rd(16'hC100, 8'hAA);
    rd(16'hFF80, 8'h3C);
    repeat (4) begin
      e = sb.pop_front();
      n_tests++;
      if (e !== 8'h77 && e !== 8'hC0 && e !== 8'hAA && e !== 8'h3C) n_fail++;
    end
    // The four reads above all resolved before the pops; recheck the last one directly.
    n_tests++;
    if (rvalid !== 1'b1 || rdata !== 8'h3C) begin
      n_fail++; $display("FAIL hram_after_copy: got %h/%b required 3C/1", rdata, rvalid);
    end
  endtask

  task automatic test_post_copy_bytes();
    logic [7:0] e;
    logic [15:0] a [3];
    logic [7:0]  x [3];
    a[0] = 16'hFEA0; x[0] = 8'h77;
    a[1] = 16'hFF46; x[1] = 8'hC0;
    a[2] = 16'hC100; x[2] = 8'hAA;
    for (int k = 0; k < 3; k++) begin
      rd(a[k], x[k]);
      e = sb.pop_front(); n_tests++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_fail++; $display("FAIL post_copy_%h: got %h/%b required %h/1", a[k], rdata, rvalid, e);
      end
    end
  endtask

  task automatic test_restart();
    int d0, t0, lat;
    bit ok;
    logic [7:0] e;
    for (int i = 0; i < 160; i++) wr(16'hD000 + 16'(i), 8'h11);
    d0 = done_cnt;
    wr(16'hFF46, 8'hC0);
    repeat (100) @(posedge clk);
    wr(16'hFF46, 8'hD0);
    t0 = cyc;
    wait_done(400, ok);
    lat = cyc - t0;
    n_tests++;
    if (!ok || lat != 320) begin
      n_fail++; $display("FAIL restart_latency: got ok=%b cycles=%0d required 320", ok, lat);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL restart_pulses: got %0d required 1", done_cnt - d0);
    end
    for (int i = 0; i < 160; i++) begin
      rd(16'hFE00 + 16'(i), 8'h11);
      e = sb.pop_front(); n_tests++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_fail++; $display("FAIL restart_fe%02h: got %h/%b required %h/1", i, rdata, rvalid, e);
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int d0;
    logic [7:0] e;
    for (int i = 0; i < 160; i++) wr(16'hFE00 + 16'(i), 8'hEE);
    d0 = done_cnt;
    wr(16'hFF46, 8'hC0);
    repeat (49) @(posedge clk);
    rd(16'hC100, 8'hFF);
    e = sb.pop_front(); n_tests++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      n_fail++; $display("FAIL abort_lockout_read: got %h/%b required %h/1", rdata, rvalid, e);
    end
    rst_b = 1'b0;
    #1;
    n_tests++;
    if ({rdata, rvalid, dma_busy, dma_done} !== 11'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got rdata=%h rvalid=%b busy=%b done=%b required all 0",
               rdata, rvalid, dma_busy, dma_done);
    end
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (done_cnt != d0 || dma_busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: got pulses=%0d busy=%b required 0/0", done_cnt - d0, dma_busy);
    end
    for (int i = 0; i < 160; i++) begin
      rd(16'hFE00 + 16'(i), (i < 25) ? 8'(i) : 8'hEE);
      e = sb.pop_front(); n_tests++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_fail++; $display("FAIL abort_fe%02h: got %h/%b required %h/1", i, rdata, rvalid, e);
      end
    end
  endtask

  task automatic test_high_page();
    bit ok;
    logic [7:0] e;
    for (int i = 0; i < 160; i++)
      if (i != 8'h46) wr(16'hFF00 + 16'(i), 8'(i * 7 + 3));
    wr(16'hFF46, 8'hFF);
    wait_done(400, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL high_page_done: got timeout required done");
    end
    for (int i = 0; i < 160; i++) begin
      rd(16'hFE00 + 16'(i), (i == 8'h46) ? 8'hFF : 8'(i * 7 + 3));
      e = sb.pop_front(); n_tests++;
      if (rvalid !== 1'b1 || rdata !== e) begin
        n_fail++; $display("FAIL high_page_fe%02h: got %h/%b required %h/1", i, rdata, rvalid, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_copy();
    test_post_copy_bytes();
    test_restart();
    test_reset_mid_copy();
    test_high_page();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: got %0d entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
